// File: rtl/core_pkg.sv
// Shared core definitions: M-unit stall FSM encoding, func3 decode index and register constants.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MDIV_BUSY = 2'd1,
        MDIV_DONE = 2'd2
    } mdiv_state_e;

    localparam int         FUNC3_DIVREM_BIT = 2;
    localparam logic [4:0] REG_X0           = 5'd0;
    localparam int         MDIV_CNT_W       = 4;

    // Busy-counter preload for an M op of the given EX latency.
    function automatic logic [MDIV_CNT_W-1:0] mdiv_cnt_load(input int lat);
        return MDIV_CNT_W'(lat - 2);
    endfunction

endpackage

// File: rtl/mdiv_stall_fsm.sv
// Multi-cycle M-extension occupancy tracker: state register plus busy counter.
// hold_o is Mealy in IDLE so the front end freezes in the very cycle the op enters EX.
module mdiv_stall_fsm
    import core_pkg::*;
#(
    parameter int DIV_LATENCY = 8,
    parameter int MUL_LATENCY = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic muldiv_i,
    input  logic divrem_i,
    output logic hold_o,
    output logic busy_o
);

    localparam logic [MDIV_CNT_W-1:0] DIV_LOAD   = mdiv_cnt_load(DIV_LATENCY);
    localparam logic [MDIV_CNT_W-1:0] MUL_LOAD   = mdiv_cnt_load(MUL_LATENCY);
    localparam bit                    MUL_STALLS = (MUL_LATENCY > 1);

    mdiv_state_e           state_q, state_d;
    logic [MDIV_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (muldiv_i && (divrem_i || MUL_STALLS)) begin
                    state_d = MDIV_BUSY;
                    cnt_d   = divrem_i ? DIV_LOAD : MUL_LOAD;
                    hold_o  = 1'b1;
                end
            end
            MDIV_BUSY: begin
                hold_o = 1'b1;
                // Leave on the last count so the DONE cycle is the op's final EX cycle;
                // a zero preload still spends one cycle here.
                if (cnt_q <= MDIV_CNT_W'(1)) begin
                    state_d = MDIV_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - MDIV_CNT_W'(1);
                end
            end
            MDIV_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, M-unit holds, redirect flushes.
// Define HAZARD_PERF_CNT_EN to add saturating perf counters (Perf_LoadUse, Perf_MDIV, Perf_Flush).
module hazard_stall_ctrl
    import core_pkg::*;
#(
    parameter int DIV_LATENCY = 8,
    parameter int MUL_LATENCY = 2
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_Uses_rs1,
    input  logic       ID_Uses_rs2,
    input  logic       EX_Mem_Read,
    input  logic [4:0] EX_WriteAddress,
    input  logic       EX_MulDiv,
    input  logic [2:0] EX_func3,
    input  logic       EX_Redirect,
    output logic       STALL,
    output logic       PC_Hold,
    output logic       IF_ID_Hold,
    output logic       IF_ID_Flush,
    output logic       EX_Hold,
    output logic       MDIV_Busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] Perf_LoadUse,
    output logic [PERF_W-1:0] Perf_MDIV,
    output logic [PERF_W-1:0] Perf_Flush
`endif
);

    logic mdiv_hold;
    logic mdiv_busy;
    logic load_use;
    logic unused_func3;

    assign unused_func3 = ^EX_func3[1:0];

    mdiv_stall_fsm #(
        .DIV_LATENCY(DIV_LATENCY),
        .MUL_LATENCY(MUL_LATENCY)
    ) u_mdiv_fsm (
        .clk_i   (CLK),
        .rst_ni  (Reset),
        .muldiv_i(EX_MulDiv),
        .divrem_i(EX_func3[FUNC3_DIVREM_BIT]),
        .hold_o  (mdiv_hold),
        .busy_o  (mdiv_busy)
    );

    // if-based decode: an unknown compare falls to the no-hazard branch.
    always_comb begin
        load_use = 1'b0;
        if (EX_Mem_Read && (EX_WriteAddress != REG_X0)) begin
            if (ID_Uses_rs1 && (ID_rs1 == EX_WriteAddress)) load_use = 1'b1;
            if (ID_Uses_rs2 && (ID_rs2 == EX_WriteAddress)) load_use = 1'b1;
        end
    end

    always_comb begin
        STALL       = 1'b0;
        PC_Hold     = 1'b0;
        IF_ID_Hold  = 1'b0;
        IF_ID_Flush = 1'b0;
        EX_Hold     = 1'b0;
        MDIV_Busy   = 1'b0;
        if (!Reset) begin
            STALL = 1'b1;
        end else begin
            MDIV_Busy = mdiv_busy;
            if (mdiv_hold) begin
                EX_Hold    = 1'b1;
                PC_Hold    = 1'b1;
                IF_ID_Hold = 1'b1;
            end else if (EX_Redirect) begin
                IF_ID_Flush = 1'b1;
                STALL       = 1'b1;
            end else if (load_use) begin
                STALL      = 1'b1;
                PC_Hold    = 1'b1;
                IF_ID_Hold = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // STALL together with PC_Hold only arises from the load-use branch.
    logic [2:0] perf_evt;
    assign perf_evt = {IF_ID_Flush, EX_Hold, STALL & PC_Hold};

    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        logic [PERF_W-1:0] cnt_q;
        always_ff @(posedge CLK or negedge Reset) begin
            if (!Reset) begin
                cnt_q <= '0;
            end else if (perf_evt[gi] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + PERF_W'(1);
            end
        end
    end

    assign Perf_LoadUse = g_perf[0].cnt_q;
    assign Perf_MDIV    = g_perf[1].cnt_q;
    assign Perf_Flush   = g_perf[2].cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus randomized traffic vs. a reference model.
module tb_hazard_stall_ctrl;

    localparam int DIV_LAT = 8;
    localparam int MUL_LAT = 2;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_WriteAddress = '0;
    logic       ID_Uses_rs1 = 1'b0, ID_Uses_rs2 = 1'b0, EX_Mem_Read = 1'b0;
    logic       EX_MulDiv = 1'b0, EX_Redirect = 1'b0;
    logic [2:0] EX_func3 = '0;
    logic       STALL, PC_Hold, IF_ID_Hold, IF_ID_Flush, EX_Hold, MDIV_Busy;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] Perf_LoadUse, Perf_MDIV, Perf_Flush;
    int          m_perf_lu, m_perf_md, m_perf_fl;
`endif

    always #5 CLK = ~CLK;

    hazard_stall_ctrl #(
        .DIV_LATENCY(DIV_LAT),
        .MUL_LATENCY(MUL_LAT)
    ) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .ID_Uses_rs1    (ID_Uses_rs1),
        .ID_Uses_rs2    (ID_Uses_rs2),
        .EX_Mem_Read    (EX_Mem_Read),
        .EX_WriteAddress(EX_WriteAddress),
        .EX_MulDiv      (EX_MulDiv),
        .EX_func3       (EX_func3),
        .EX_Redirect    (EX_Redirect),
        .STALL          (STALL),
        .PC_Hold        (PC_Hold),
        .IF_ID_Hold     (IF_ID_Hold),
        .IF_ID_Flush    (IF_ID_Flush),
        .EX_Hold        (EX_Hold),
        .MDIV_Busy      (MDIV_Busy)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .Perf_LoadUse   (Perf_LoadUse),
        .Perf_MDIV      (Perf_MDIV),
        .Perf_Flush     (Perf_Flush)
`endif
    );

    // {STALL, PC_Hold, IF_ID_Hold, IF_ID_Flush, EX_Hold, MDIV_Busy}
    logic [5:0] obs;
    assign obs = {STALL, PC_Hold, IF_ID_Hold, IF_ID_Flush, EX_Hold, MDIV_Busy};

    int checks = 0;
    int errors = 0;

    // Reference model: an M op sits in EX for a number of held cycles, then one released cycle.
    int m_busy_left = 0;
    bit m_done = 1'b0;

    // Cycles spent after the start cycle before the release cycle; at least one.
    function automatic int busy_len(input bit divrem);
        int lat;
        lat = divrem ? DIV_LAT : MUL_LAT;
        return (lat - 2 < 1) ? 1 : lat - 2;
    endfunction

    function automatic logic [5:0] model_out();
        bit idle, start, hold, lu, busy;
        if (!Reset) return 6'b100000;
        idle  = (m_busy_left == 0) && !m_done;
        start = EX_MulDiv && (EX_func3[2] || (MUL_LAT > 1));
        hold  = (m_busy_left > 0) || (idle && start);
        busy  = !idle;
        lu    = EX_Mem_Read && (EX_WriteAddress != 5'd0) &&
                ((ID_Uses_rs1 && ID_rs1 == EX_WriteAddress) ||
                 (ID_Uses_rs2 && ID_rs2 == EX_WriteAddress));
        if (hold)             return {5'b01101, busy};
        else if (EX_Redirect) return {5'b10010, busy};
        else if (lu)          return {5'b11100, busy};
        return {5'b00000, busy};
    endfunction

    task automatic model_edge();
        logic [5:0] o;
        bit start, idle;
        if (!Reset) begin
            m_busy_left = 0;
            m_done      = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
            m_perf_lu = 0; m_perf_md = 0; m_perf_fl = 0;
`endif
            return;
        end
        o     = model_out();
`ifdef HAZARD_PERF_CNT_EN
        if (o[5] && o[4]) m_perf_lu++;
        if (o[1])         m_perf_md++;
        if (o[2])         m_perf_fl++;
`endif
        idle  = (m_busy_left == 0) && !m_done;
        start = EX_MulDiv && (EX_func3[2] || (MUL_LAT > 1));
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (idle && start) begin
            m_busy_left = busy_len(EX_func3[2]);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        ID_rs1 = '0; ID_rs2 = '0; ID_Uses_rs1 = 0; ID_Uses_rs2 = 0;
        EX_Mem_Read = 0; EX_WriteAddress = '0; EX_MulDiv = 0; EX_func3 = '0; EX_Redirect = 0;
    endtask

    task automatic rand_inputs();
        ID_rs1          = 5'($urandom_range(0, 3));
        ID_rs2          = 5'($urandom_range(0, 3));
        ID_Uses_rs1     = 1'($urandom_range(0, 1));
        ID_Uses_rs2     = 1'($urandom_range(0, 1));
        EX_Mem_Read     = 1'($urandom_range(0, 1));
        EX_WriteAddress = 5'($urandom_range(0, 3));
        EX_MulDiv       = ($urandom_range(0, 3) == 0);
        EX_func3        = 3'($urandom_range(0, 7));
        EX_Redirect     = ($urandom_range(0, 4) == 0);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            @(negedge CLK);
            checks++;
            if (obs !== 6'b100000) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got %b required %b", i, obs, 6'b100000);
            end
            tick();
        end
        Reset = 1'b1;
        clear_inputs();
        $display("test_reset: done");
    endtask

    task automatic test_load_use();
        logic [5:0] req [4] = '{6'b111000, 6'b000000, 6'b111000, 6'b000000};
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: begin EX_Mem_Read = 1; EX_WriteAddress = 5; ID_rs1 = 5; ID_Uses_rs1 = 1; end
                1: begin EX_Mem_Read = 0; EX_WriteAddress = 5; ID_rs1 = 5; ID_Uses_rs1 = 1; end
                2: begin EX_Mem_Read = 1; EX_WriteAddress = 7; ID_rs1 = 7; ID_rs2 = 7; ID_Uses_rs2 = 1; end
                default: begin EX_Mem_Read = 1; EX_WriteAddress = 7; ID_rs1 = 7; ID_rs2 = 7; end
            endcase
            @(negedge CLK);
            checks++;
            if (obs !== req[i]) begin
                errors++;
                $display("FAIL load_use step%0d: got %b required %b", i, obs, req[i]);
            end
            tick();
        end
        clear_inputs();
        EX_Mem_Read = 1; EX_WriteAddress = 0; ID_rs1 = 0; ID_Uses_rs1 = 1;
        @(negedge CLK);
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL x0_target: got %b required %b", obs, 6'b000000);
        end
        tick();
        clear_inputs();
        $display("test_load_use: done");
    endtask

    // Runs n_ops back-to-back DIVs; each is held DIV_LAT-1 cycles then released for one.
    task automatic test_div(input int n_ops, input bit redirect_mid, input string tag);
        int holds;
        logic [5:0] req;
        holds = 0;
        clear_inputs();
        EX_MulDiv = 1; EX_func3 = 3'b100;
        for (int i = 0; i < n_ops * DIV_LAT; i++) begin
            int j;
            j = i % DIV_LAT;
            EX_Redirect = redirect_mid && (j >= 2) && (j <= 4);
            EX_Mem_Read = EX_Redirect; EX_WriteAddress = 3; ID_rs1 = 3; ID_Uses_rs1 = EX_Redirect;
            req = (j < DIV_LAT - 1) ? {5'b01101, (j > 0)} : 6'b000001;
            @(negedge CLK);
            if (EX_Hold === 1'b1) holds++;
            checks++;
            if (obs !== req) begin
                errors++;
                $display("FAIL %s cyc%0d: got %b required %b", tag, i, obs, req);
            end
            tick();
        end
        clear_inputs();
        @(negedge CLK);
        checks++;
        if (obs !== 6'b000000) begin
            errors++;
            $display("FAIL %s idle_after: got %b required %b", tag, obs, 6'b000000);
        end
        checks++;
        if (holds != n_ops * (DIV_LAT - 1)) begin
            errors++;
            $display("FAIL %s hold_count: got %0d required %0d", tag, holds, n_ops * (DIV_LAT - 1));
        end
        tick();
        $display("%s: done", tag);
    endtask

    task automatic test_mul();
        logic [5:0] req [3] = '{6'b011010, 6'b011011, 6'b000001};
        clear_inputs();
        EX_MulDiv = 1; EX_func3 = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (obs !== req[i]) begin
                errors++;
                $display("FAIL mul cyc%0d: got %b required %b", i, obs, req[i]);
            end
            tick();
        end
        clear_inputs();
        $display("test_mul: done");
    endtask

    task automatic test_redirect();
        clear_inputs();
        EX_Redirect = 1; EX_Mem_Read = 1; EX_WriteAddress = 9; ID_rs2 = 9; ID_Uses_rs2 = 1;
        @(negedge CLK);
        checks++;
        if (obs !== 6'b100100) begin
            errors++;
            $display("FAIL redirect_loaduse: got %b required %b", obs, 6'b100100);
        end
        tick();
        clear_inputs();
        EX_Redirect = 1;
        @(negedge CLK);
        checks++;
        if (obs !== 6'b100100) begin
            errors++;
            $display("FAIL redirect_only: got %b required %b", obs, 6'b100100);
        end
        tick();
        clear_inputs();
        $display("test_redirect: done");
    endtask

    task automatic test_async_reset();
        clear_inputs();
        EX_MulDiv = 1; EX_func3 = 3'b110;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            checks++;
            if (obs !== {5'b01101, (i > 0)}) begin
                errors++;
                $display("FAIL areset_pre cyc%0d: got %b required %b", i, obs, {5'b01101, (i > 0)});
            end
            if (i < 4) tick();
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if (obs !== 6'b100000) begin
            errors++;
            $display("FAIL areset_immediate: got %b required %b", obs, 6'b100000);
        end
        tick();
        Reset = 1'b1;
        $display("test_async_reset: reset applied");
        test_div(1, 1'b0, "div_after_reset");
    endtask

    task automatic test_random();
        logic [5:0] exp;
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            Reset = ($urandom_range(0, 59) != 0);
            @(negedge CLK);
            exp = model_out();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random cyc%0d: got %b required %b", i, obs, exp);
            end
            tick();
        end
        Reset = 1'b1;
        clear_inputs();
`ifdef HAZARD_PERF_CNT_EN
        @(negedge CLK);
        checks++;
        if (Perf_LoadUse !== 32'(m_perf_lu) || Perf_MDIV !== 32'(m_perf_md) || Perf_Flush !== 32'(m_perf_fl)) begin
            errors++;
            $display("FAIL random_perf: got %0d/%0d/%0d required %0d/%0d/%0d",
                     Perf_LoadUse, Perf_MDIV, Perf_Flush, m_perf_lu, m_perf_md, m_perf_fl);
        end
        tick();
`endif
        $display("test_random: done");
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf();
        clear_inputs();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        EX_Mem_Read = 1; EX_WriteAddress = 4; ID_rs1 = 4; ID_Uses_rs1 = 1;
        tick();
        clear_inputs();
        EX_MulDiv = 1; EX_func3 = 3'b101;
        for (int i = 0; i < DIV_LAT; i++) tick();
        clear_inputs();
        EX_Redirect = 1;
        tick();
        clear_inputs();
        @(negedge CLK);
        checks++;
        if (Perf_LoadUse !== 32'd1 || Perf_MDIV !== 32'd7 || Perf_Flush !== 32'd1) begin
            errors++;
            $display("FAIL perf_counts: got %0d/%0d/%0d required 1/7/1", Perf_LoadUse, Perf_MDIV, Perf_Flush);
        end
        tick();
        $display("test_perf: done");
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_div(1, 1'b0, "div_single");
        test_div(2, 1'b0, "div_back_to_back");
        test_div(1, 1'b1, "div_redirect_ignored");
        test_mul();
        test_redirect();
        test_async_reset();
        test_random();
`ifdef HAZARD_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
